// File: rtl/stage2_pkg.sv
// Shared types and constants for the stage2 leg-geometry solver:
// FSM states, port widths, fixed-point defaults and saturation limits.
package stage2_pkg;
  localparam int FRAC_BITS_DEF = 12;
  localparam int DIV_ITER_DEF  = 28;

  localparam int L_W       = 16;
  localparam int M_W       = 14;
  localparam int N_W       = 15;
  localparam int SQ_W      = 30;
  localparam int RADIUS_W  = 15;
  localparam int RATIO_L_W = 13;
  localparam int RATIO_N_W = 16;

  localparam int RATIO_L_MAX = 4096;
  localparam int RATIO_N_MAX = 32767;

  typedef enum logic [2:0] {
    IDLE,
    SQUARE,
    SQRT,
    DIV_L,
    DIV_N,
    DONE
  } state_e;

  typedef struct packed {
    logic [RATIO_L_W-1:0] value;
    logic                 unreach;
  } ratio_l_t;

  typedef struct packed {
    logic signed [RATIO_N_W-1:0] value;
    logic                        div_zero;
    logic                        sat;
  } ratio_n_t;
endpackage

// File: rtl/stage2_if.sv
// Request/result bundle of stage2: one-cycle request strobe with leg terms,
// busy/overrun status and the registered result set with its strobe.
interface stage2_if;
  import stage2_pkg::*;

  logic                        valid;
  logic        [L_W-1:0]       L;
  logic        [M_W-1:0]       M;
  logic signed [N_W-1:0]       N;
  logic                        busy;
  logic        [RADIUS_W-1:0]  radius;
  logic        [RATIO_L_W-1:0] ratio_l;
  logic signed [RATIO_N_W-1:0] ratio_n;
  logic                        unreachable;
  logic                        div_zero;
  logic                        sat_n;
  logic                        overrun;
  logic                        out_valid;

  modport master (
    output valid, L, M, N,
    input  busy, radius, ratio_l, ratio_n, unreachable, div_zero, sat_n,
           overrun, out_valid
  );

  modport slave (
    input  valid, L, M, N,
    output busy, radius, ratio_l, ratio_n, unreachable, div_zero, sat_n,
           overrun, out_valid
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// The first iteration runs on the start edge; done flags the last iteration.
module seq_divider #(
  parameter int DIV_ITER = 28,
  parameter int DVS_W    = 15
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                start,
  input  logic [DIV_ITER-1:0] dividend,
  input  logic [DVS_W-1:0]    divisor,
  output logic                busy,
  output logic                done,
  output logic [DIV_ITER-1:0] quotient
);
  localparam int CNT_W = $clog2(DIV_ITER + 1);
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(DIV_ITER - 1);

  logic [DVS_W-1:0]    rem_q, rem_d, cur_rem;
  logic [DIV_ITER-1:0] quo_q, quo_d, cur_quo;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DVS_W:0]      trial;

  always_comb begin
    cur_rem = start ? '0 : rem_q;
    cur_quo = start ? dividend : quo_q;
    trial   = {cur_rem, cur_quo[DIV_ITER-1]};
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    if (start || cnt_q != '0) begin
      if (trial >= {1'b0, divisor}) begin
        rem_d = DVS_W'(trial - {1'b0, divisor});
        quo_d = {cur_quo[DIV_ITER-2:0], 1'b1};
      end else begin
        rem_d = trial[DVS_W-1:0];
        quo_d = {cur_quo[DIV_ITER-2:0], 1'b0};
      end
      cnt_d = start ? ITER_LAST : cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy     = (cnt_q != '0);
  assign done     = (cnt_q == CNT_W'(1));
  assign quotient = quo_q;
endmodule

// File: rtl/stage2.sv
// Leg solver: radius = isqrt(M^2+N^2), ratio_l = L/radius (Q1.12),
// ratio_n = N/M (Q3.12), computed serially with fixed latency.
module stage2
  import stage2_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int DIV_ITER  = DIV_ITER_DEF
) (
  input  logic     clock,
  input  logic     rst,
  stage2_if.slave  bus
);
  state_e                      state_q, state_d;
  logic        [L_W-1:0]       l_q, l_d;
  logic        [M_W-1:0]       m_q, m_d;
  logic signed [N_W-1:0]       n_q, n_d;
  logic        [SQ_W-1:0]      s_q, s_d;
  logic        [RADIUS_W+2:0]  sq_rem_q, sq_rem_d, sq_acc, sq_trial;
  logic        [RADIUS_W-1:0]  root_q, root_d;
  logic        [3:0]           sq_cnt_q, sq_cnt_d;
  logic        [DIV_ITER-1:0]  q_l_q, q_l_d;
  logic        [RADIUS_W-1:0]  radius_q, radius_d;
  logic        [RATIO_L_W-1:0] ratio_l_q, ratio_l_d;
  logic signed [RATIO_N_W-1:0] ratio_n_q, ratio_n_d;
  logic                        unreachable_q, unreachable_d;
  logic                        div_zero_q, div_zero_d;
  logic                        sat_n_q, sat_n_d;
  logic                        overrun_q, overrun_d;
  logic                        out_valid_q, out_valid_d;

  logic        [N_W-1:0]       n_abs;
  logic                        div_start, div_busy, div_done;
  logic        [DIV_ITER-1:0]  div_dividend, div_quotient;
  logic        [RADIUS_W-1:0]  div_divisor;
  ratio_l_t                    rl;
  ratio_n_t                    rn;

  function automatic ratio_l_t sat_ratio_l(input logic [DIV_ITER-1:0] q,
                                           input logic [RADIUS_W-1:0] r);
    ratio_l_t res;
    if (r == '0 || q > DIV_ITER'(RATIO_L_MAX)) begin
      res.value   = RATIO_L_W'(RATIO_L_MAX);
      res.unreach = 1'b1;
    end else begin
      res.value   = q[RATIO_L_W-1:0];
      res.unreach = 1'b0;
    end
    return res;
  endfunction

  // M=0 bypasses the quotient entirely; otherwise clip magnitude, then apply sign of N.
  function automatic ratio_n_t sat_ratio_n(input logic [DIV_ITER-1:0] q,
                                           input logic m_zero,
                                           input logic signed [N_W-1:0] n);
    ratio_n_t                    res;
    logic signed [RATIO_N_W-1:0] mag;
    mag          = RATIO_N_W'(RATIO_N_MAX);
    res.value    = '0;
    res.div_zero = m_zero;
    res.sat      = 1'b0;
    if (m_zero) begin
      if (n > 0)      res.value = mag;
      else if (n < 0) res.value = -mag;
    end else begin
      if (q > DIV_ITER'(RATIO_N_MAX)) res.sat = 1'b1;
      else                            mag = $signed(q[RATIO_N_W-1:0]);
      res.value = n[N_W-1] ? -mag : mag;
    end
    return res;
  endfunction

  seq_divider #(
    .DIV_ITER (DIV_ITER),
    .DVS_W    (RADIUS_W)
  ) u_div (
    .clock    (clock),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_comb begin
    state_d       = state_q;
    l_d           = l_q;
    m_d           = m_q;
    n_d           = n_q;
    s_d           = s_q;
    sq_rem_d      = sq_rem_q;
    root_d        = root_q;
    sq_cnt_d      = sq_cnt_q;
    q_l_d         = q_l_q;
    radius_d      = radius_q;
    ratio_l_d     = ratio_l_q;
    ratio_n_d     = ratio_n_q;
    unreachable_d = unreachable_q;
    div_zero_d    = div_zero_q;
    sat_n_d       = sat_n_q;
    overrun_d     = overrun_q;
    out_valid_d   = 1'b0;
    div_start     = 1'b0;

    n_abs        = n_q[N_W-1] ? N_W'(-n_q) : N_W'(n_q);
    sq_acc       = {sq_rem_q[RADIUS_W:0], s_q[SQ_W-1 -: 2]};
    sq_trial     = {1'b0, root_q, 2'b01};
    div_dividend = (state_q == DIV_N) ? (DIV_ITER'(n_abs) << FRAC_BITS)
                                      : (DIV_ITER'(l_q) << FRAC_BITS);
    div_divisor  = (state_q == DIV_N) ? RADIUS_W'(m_q) : root_q;
    rl           = sat_ratio_l(q_l_q, root_q);
    rn           = sat_ratio_n(div_quotient, m_q == '0, n_q);

    if (bus.valid && state_q != IDLE) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          l_d     = bus.L;
          m_d     = bus.M;
          n_d     = bus.N;
          state_d = SQUARE;
        end
      end
      SQUARE: begin
        s_d      = SQ_W'(m_q) * SQ_W'(m_q) + SQ_W'(n_abs) * SQ_W'(n_abs);
        sq_rem_d = '0;
        root_d   = '0;
        sq_cnt_d = '0;
        state_d  = SQRT;
      end
      SQRT: begin
        if (sq_acc >= sq_trial) begin
          sq_rem_d = sq_acc - sq_trial;
          root_d   = {root_q[RADIUS_W-2:0], 1'b1};
        end else begin
          sq_rem_d = sq_acc;
          root_d   = {root_q[RADIUS_W-2:0], 1'b0};
        end
        s_d      = {s_q[SQ_W-3:0], 2'b00};
        sq_cnt_d = sq_cnt_q + 4'd1;
        if (sq_cnt_q == 4'(RADIUS_W - 1)) state_d = DIV_L;
      end
      DIV_L: begin
        div_start = !div_busy;
        if (div_done) state_d = DIV_N;
      end
      DIV_N: begin
        // Divider still holds the L quotient on its start cycle.
        div_start = !div_busy;
        if (div_start) q_l_d = div_quotient;
        if (div_done) state_d = DONE;
      end
      DONE: begin
        radius_d      = root_q;
        ratio_l_d     = rl.value;
        unreachable_d = rl.unreach;
        ratio_n_d     = rn.value;
        div_zero_d    = rn.div_zero;
        sat_n_d       = rn.sat;
        out_valid_d   = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= IDLE;
      l_q           <= '0;
      m_q           <= '0;
      n_q           <= '0;
      s_q           <= '0;
      sq_rem_q      <= '0;
      root_q        <= '0;
      sq_cnt_q      <= '0;
      q_l_q         <= '0;
      radius_q      <= '0;
      ratio_l_q     <= '0;
      ratio_n_q     <= '0;
      unreachable_q <= 1'b0;
      div_zero_q    <= 1'b0;
      sat_n_q       <= 1'b0;
      overrun_q     <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      l_q           <= l_d;
      m_q           <= m_d;
      n_q           <= n_d;
      s_q           <= s_d;
      sq_rem_q      <= sq_rem_d;
      root_q        <= root_d;
      sq_cnt_q      <= sq_cnt_d;
      q_l_q         <= q_l_d;
      radius_q      <= radius_d;
      ratio_l_q     <= ratio_l_d;
      ratio_n_q     <= ratio_n_d;
      unreachable_q <= unreachable_d;
      div_zero_q    <= div_zero_d;
      sat_n_q       <= sat_n_d;
      overrun_q     <= overrun_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.radius      = radius_q;
  assign bus.ratio_l     = ratio_l_q;
  assign bus.ratio_n     = ratio_n_q;
  assign bus.unreachable = unreachable_q;
  assign bus.div_zero    = div_zero_q;
  assign bus.sat_n       = sat_n_q;
  assign bus.overrun     = overrun_q;
  assign bus.out_valid   = out_valid_q;
endmodule

// File: tb/tb_stage2.sv
// Scoreboard bench for stage2: directed vectors push expected results,
// a negedge monitor pops and compares on every out_valid strobe.
module tb_stage2;
  import stage2_pkg::*;

  typedef struct {
    int radius;
    int ratio_l;
    int ratio_n;
    int unreach;
    int dz;
    int sat;
    int cyc;
  } exp_t;

  logic clock = 1'b0;
  logic rst;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   ov_seen = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  stage2_if bus();

  stage2 dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input int r, input int rl, input int rn,
                              input int u, input int dz, input int s);
    exp_t e;
    e.radius = r; e.ratio_l = rl; e.ratio_n = rn;
    e.unreach = u; e.dz = dz; e.sat = s; e.cyc = 0;
    return e;
  endfunction

  // Called at a negedge; the next posedge is the capture edge.
  task automatic issue(input int l, input int m, input int n, input bit push, input exp_t e);
    exp_t x;
    x = e;
    bus.valid = 1'b1;
    bus.L = 16'(l);
    bus.M = 14'(m);
    bus.N = 15'(n);
    x.cyc = cyc + 74;
    if (push) exp_q.push_back(x);
    @(negedge clock);
    bus.valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  always @(negedge clock) begin
    if (bus.out_valid === 1'b1) begin
      ov_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("latency_cycle", cyc, mon_e.cyc);
        check("radius", int'(bus.radius), mon_e.radius);
        check("ratio_l", int'(bus.ratio_l), mon_e.ratio_l);
        check("ratio_n", int'(bus.ratio_n), mon_e.ratio_n);
        check("unreachable", int'(bus.unreachable), mon_e.unreach);
        check("div_zero", int'(bus.div_zero), mon_e.dz);
        check("sat_n", int'(bus.sat_n), mon_e.sat);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int ov_before;
    rst = 1'b1;
    bus.valid = 1'b0;
    bus.L = '0;
    bus.M = '0;
    bus.N = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_radius", int'(bus.radius), 0);
    check("rst_ratio_l", int'(bus.ratio_l), 0);
    check("rst_ratio_n", int'(bus.ratio_n), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    rst = 1'b0;
    @(negedge clock);

    issue(2500, 3000, 4000, 1'b1, mk(5000, 2048, 5461, 0, 0, 0));
    check("busy_after_capture", int'(bus.busy), 1);
    wait_drain(120);
    issue(2500, 3000, -4000, 1'b1, mk(5000, 2048, -5461, 0, 0, 0));
    wait_drain(120);
    issue(12000, 100, 12000, 1'b1, mk(12000, 4096, 32767, 0, 0, 1));
    wait_drain(120);
    repeat (5) @(negedge clock);
    check("hold_radius", int'(bus.radius), 12000);
    check("hold_ratio_n", int'(bus.ratio_n), 32767);
    check("hold_out_valid_low", int'(bus.out_valid), 0);
    check("idle_busy", int'(bus.busy), 0);
    issue(0, 0, 0, 1'b1, mk(0, 4096, 0, 1, 1, 0));
    wait_drain(120);
    check("overrun_clear", int'(bus.overrun), 0);

    // Second valid 10 cycles after the first is dropped and flagged.
    issue(2500, 3000, 4000, 1'b1, mk(5000, 2048, 5461, 0, 0, 0));
    repeat (9) @(negedge clock);
    issue(100, 100, 100, 1'b0, mk(0, 0, 0, 0, 0, 0));
    check("overrun_set", int'(bus.overrun), 1);
    check("busy_during_overrun", int'(bus.busy), 1);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 120) begin
      @(negedge clock);
      n++;
    end
    check("out_valid_seen", int'(bus.out_valid === 1'b1), 1);
    issue(12000, 100, -12000, 1'b1, mk(12000, 4096, -32767, 0, 0, 1));
    wait_drain(120);
    check("overrun_sticky", int'(bus.overrun), 1);

    // Abort mid-computation.
    issue(2500, 3000, 4000, 1'b0, mk(0, 0, 0, 0, 0, 0));
    repeat (29) @(negedge clock);
    check("busy_before_abort", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clock);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_radius", int'(bus.radius), 0);
    check("abort_ratio_l", int'(bus.ratio_l), 0);
    check("abort_ratio_n", int'(bus.ratio_n), 0);
    check("abort_flags", int'({bus.unreachable, bus.div_zero, bus.sat_n}), 0);
    check("abort_overrun", int'(bus.overrun), 0);
    rst = 1'b0;
    ov_before = ov_seen;
    repeat (100) @(negedge clock);
    check("no_out_valid_after_abort", ov_seen - ov_before, 0);

    issue(2500, 3000, 4000, 1'b1, mk(5000, 2048, 5461, 0, 0, 0));
    wait_drain(120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage2.md
STAGE2 -- requirements
Module: stage2

Interface
REQ-001 The module SHALL have parameter FRAC_BITS, default 12, fixed-point fraction bits of both ratio outputs.
REQ-002 The module SHALL have parameter DIV_ITER, default 28, restoring-divider iterations (equals dividend width).
REQ-003 The module SHALL have port clock  input  1  rising-edge clock.
REQ-004 The module SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The module SHALL have port valid  input  1  single-cycle strobe qualifying L, M, N.
REQ-006 The module SHALL have port L  input  16  unsigned leg term L.
REQ-007 The module SHALL have port M  input  14  unsigned leg term M.
REQ-008 The module SHALL have port N  input  15  signed leg term N.
REQ-009 The module SHALL have port busy  output  1  high in every cycle the FSM is not IDLE.
REQ-010 The module SHALL have port radius  output  15  isqrt(M^2+N^2), floor.
REQ-011 The module SHALL have port ratio_l  output  13  unsigned Q1.12 L/radius, max 4096.
REQ-012 The module SHALL have port ratio_n  output  16  signed Q3.12 N/M.
REQ-013 The module SHALL have port unreachable  output  1  L/radius exceeded 1.0 or radius was 0.
REQ-014 The module SHALL have port div_zero  output  1  M was 0.
REQ-015 The module SHALL have port sat_n  output  1  ratio_n clipped.
REQ-016 The module SHALL have port overrun  output  1  sticky; a valid arrived while busy.
REQ-017 The module SHALL have port out_valid  output  1  one-cycle strobe; result outputs updated.

Function
REQ-018 The FSM SHALL have states IDLE, SQUARE, SQRT, DIV_L, DIV_N, DONE.
REQ-019 In IDLE, valid=1 SHALL capture L, M, N into internal registers and move to SQUARE.
REQ-020 SQUARE SHALL compute S = M*M + N*N (30-bit unsigned) in one cycle, then move to SQRT.
REQ-021 SQRT SHALL run a bit-serial restoring square root, one result bit per cycle, 15 cycles, giving R = floor(sqrt(S)).
REQ-022 DIV_L SHALL divide (L << FRAC_BITS) by R over DIV_ITER cycles.
REQ-023 DIV_N SHALL divide (|N| << FRAC_BITS) by M over DIV_ITER cycles, then apply the sign of N (truncation toward zero).
REQ-024 ratio_l SHALL be the quotient when the quotient is <= 4096; otherwise, or when R=0, ratio_l SHALL be 4096 and unreachable=1.
REQ-025 When M=0, ratio_n SHALL be +32767 if N>0, -32767 if N<0, and 0 if N=0, with div_zero=1.
REQ-026 When |quotient| > 32767 and M != 0, ratio_n SHALL be ±32767 with the sign of N and sat_n=1.
REQ-027 DONE SHALL register radius, ratio_l, ratio_n, unreachable, div_zero and sat_n, pulse out_valid for one cycle, and return to IDLE on the same edge.
REQ-028 Latency SHALL be fixed: out_valid is high in the cycle after edge 1+1+15+2*DIV_ITER, which is 73 cycles after the capture edge with default parameters.
REQ-029 A valid arriving while busy=1 SHALL be dropped without disturbing the computation in progress, and SHALL set overrun.
REQ-030 A valid arriving in the out_valid cycle SHALL be accepted, because the FSM is already in IDLE.
REQ-031 Result outputs SHALL hold their values between out_valid strobes.

Reset
REQ-032 rst SHALL force IDLE and clear all outputs and internal registers to 0, including overrun; no out_valid SHALL follow.
REQ-033 rst asserted mid-computation SHALL abort the computation, with busy=0 in the cycle after the reset edge.

Structure
REQ-034 A shared package SHALL hold the FSM state typedef, the FRAC_BITS default, the saturation constants 4096 and 32767, and the input/output widths.
REQ-035 One sub-module, seq_divider, SHALL provide the iterative unsigned restoring divider (start/done handshake, DIV_ITER iterations), instantiated once and reused for both DIV_L and DIV_N.

Verification
REQ-036 The bench SHALL cover: L=2500, M=3000, N=4000 -> radius=5000, ratio_l=2048, ratio_n=5461, all flags 0, out_valid 73 cycles after valid.
REQ-037 The bench SHALL cover: L=2500, M=3000, N=-4000 -> ratio_n=-5461, radius=5000.
REQ-038 The bench SHALL cover: L=12000, M=100, N=12000 -> radius=12000, ratio_l=4096, unreachable=0, ratio_n=32767, sat_n=1.
REQ-039 The bench SHALL cover: L=0, M=0, N=0 -> radius=0, ratio_l=4096, unreachable=1, div_zero=1, ratio_n=0.
REQ-040 The bench SHALL cover: second valid 10 cycles after the first -> overrun=1, first result unchanged; third valid in the out_valid cycle -> accepted, next out_valid 73 cycles later.
REQ-041 The bench SHALL cover: rst at cycle 30 of a computation -> busy=0 next cycle, all outputs 0, no out_valid.
